cache_bus_arbiter: RTL and testbench

Two-to-one arbiter that shares the single system-bus port between the instruction cache and the data cache. It accepts requests on two `ArbiterCacheInterface.ArbiterPorts` instances and grants exactly one transaction at a time to the bus-side `ArbiterCacheInterface.CachePorts` instance. A transaction is the address beat plus either write-data beats or read-response beats. The arbiter routes response beats back to the owning cache and releases the bus only when the transaction completes.

---
 rtl/cache_bus_pkg.sv | 35 +++
 rtl/cache_bus_arbiter_if.sv | 29 ++
 rtl/cache_bus_arbiter_rr_pick.sv | 39 +++
 rtl/cache_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_bus_pkg.sv
// Shared types and tag-field constants for the cache bus arbiter.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  typedef enum logic [3:0] {
    TYPE_MEMORY = 4'd0,
    TYPE_MMIO   = 4'd1,
    TYPE_PORT   = 4'd2,
    TYPE_IRQ    = 4'd3
  } req_type_t;

  localparam int TAG_RW_BIT   = 12;
  localparam int TAG_TYPE_MSB = 11;
  localparam int TAG_TYPE_LSB = 8;

  localparam logic TAG_READ  = 1'b1;
  localparam logic TAG_WRITE = 1'b0;

  function automatic logic tag_is_write(input logic [12:0] tag);
    return (tag[TAG_RW_BIT] == TAG_WRITE);
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Request/response channel between a cache and the arbiter, and between the
// arbiter and the system bus.
interface ArbiterCacheInterface #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
) ();

  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  reqcyc;
  logic                  reqack;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;
  logic                  respcyc;
  logic                  respack;

  // Arbiter's view of a requesting cache.
  modport ArbiterPorts (
    input  req, reqtag, reqcyc, respack,
    output reqack, resp, resptag, respcyc
  );

  // Cache-side view, used by the arbiter toward the system bus.
  modport CachePorts (
    output req, reqtag, reqcyc, respack,
    input  reqack, resp, resptag, respcyc
  );

endinterface

// File: rtl/cache_bus_arbiter_rr_pick.sv
// Two-way round-robin pick: bit 0 is icache, bit 1 is dcache. The pointer
// remembers which cache was granted last so the other wins the next tie.
module arb_rr_pick (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer update; ptr_q = 1 means dcache goes first.
  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant_o = req_i;
    end
    if (accept_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, icache first out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one system-bus port between icache and dcache, one transaction at a time.
// Build option: ARB_DCACHE_PRIORITY_EN selects fixed dcache priority on contention.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  ArbiterCacheInterface.ArbiterPorts        icache,
  ArbiterCacheInterface.ArbiterPorts        dcache,
  ArbiterCacheInterface.CachePorts          bus
);

  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t             state_q, state_d;
  arb_owner_t             owner_q, owner_d;
  logic                   is_write_q, is_write_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [1:0]             req_s;
  logic [1:0]             grant_s;
  logic                   accept_s;
  logic [TAG_WIDTH-1:0]   win_tag_s;

  logic [DATA_WIDTH-1:0]  own_req_s;
  logic [TAG_WIDTH-1:0]   own_reqtag_s;
  logic                   own_reqcyc_s;
  logic                   own_respack_s;

  assign req_s     = {dcache.reqcyc, icache.reqcyc};
  assign accept_s  = (state_q == IDLE);
  assign win_tag_s = grant_s[1] ? dcache.reqtag : icache.reqtag;

`ifdef ARB_DCACHE_PRIORITY_EN
  // Fixed pick: dcache wins any tie, a lone requester wins outright.
  always_comb begin
    if (req_s[1]) begin
      grant_s = 2'b10;
    end else begin
      grant_s = req_s;
    end
  end
`else
  arb_rr_pick u_pick (
    .clk      (clk),
    .rst      (reset),
    .req_i    (req_s),
    .accept_i (accept_s),
    .grant_o  (grant_s)
  );
`endif

  // Mux the current owner's request-side inputs.
  always_comb begin
    own_req_s     = '0;
    own_reqtag_s  = '0;
    own_reqcyc_s  = 1'b0;
    own_respack_s = 1'b0;
    case (owner_q)
      OWN_I: begin
        own_req_s     = icache.req;
        own_reqtag_s  = icache.reqtag;
        own_reqcyc_s  = icache.reqcyc;
        own_respack_s = icache.respack;
      end
      OWN_D: begin
        own_req_s     = dcache.req;
        own_reqtag_s  = dcache.reqtag;
        own_reqcyc_s  = dcache.reqcyc;
        own_respack_s = dcache.respack;
      end
      default: begin
        own_req_s     = '0;
        own_reqtag_s  = '0;
        own_reqcyc_s  = 1'b0;
        own_respack_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic; the beat counter wraps to 0 on the terminal beat.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          state_d    = ADDR;
          owner_d    = grant_s[1] ? OWN_D : OWN_I;
          is_write_d = tag_is_write(win_tag_s);
          cnt_d      = '0;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      ADDR: begin
        if (!own_reqcyc_s) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end else if (bus.reqack) begin
          state_d = is_write_q ? WDATA : RESP;
          cnt_d   = '0;
        end else begin
          state_d = ADDR;
        end
      end
      WDATA: begin
        if (own_reqcyc_s && bus.reqack) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      RESP: begin
        if (bus.respcyc && own_respack_s) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Combinational forwarding between the owner and the bus; all quiet otherwise.
  always_comb begin
    bus.req        = '0;
    bus.reqtag     = '0;
    bus.reqcyc     = 1'b0;
    bus.respack    = 1'b0;
    icache.reqack  = 1'b0;
    icache.resp    = '0;
    icache.resptag = '0;
    icache.respcyc = 1'b0;
    dcache.reqack  = 1'b0;
    dcache.resp    = '0;
    dcache.resptag = '0;
    dcache.respcyc = 1'b0;
    case (state_q)
      ADDR, WDATA: begin
        bus.req    = own_req_s;
        bus.reqtag = own_reqtag_s;
        bus.reqcyc = own_reqcyc_s;
        case (owner_q)
          OWN_I:   icache.reqack = bus.reqack;
          OWN_D:   dcache.reqack = bus.reqack;
          default: bus.reqcyc    = 1'b0;
        endcase
      end
      RESP: begin
        bus.respack = own_respack_s;
        case (owner_q)
          OWN_I: begin
            icache.resp    = bus.resp;
            icache.resptag = bus.resptag;
            icache.respcyc = bus.respcyc;
          end
          OWN_D: begin
            dcache.resp    = bus.resp;
            dcache.resptag = bus.resptag;
            dcache.respcyc = bus.respcyc;
          end
          default: bus.respack = 1'b0;
        endcase
      end
      default: bus.respack = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: cache and bus models feed a scoreboard of
// expected bus addresses, write beats, per-cache read beats and grant gaps.
module tb_cache_bus_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ArbiterCacheInterface #(.DATA_WIDTH(64), .TAG_WIDTH(13)) icache_if ();
  ArbiterCacheInterface #(.DATA_WIDTH(64), .TAG_WIDTH(13)) dcache_if ();
  ArbiterCacheInterface #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus_if ();

  cache_bus_arbiter #(.DATA_WIDTH(64), .TAG_WIDTH(13), .BEATS(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .icache (icache_if),
    .dcache (dcache_if),
    .bus    (bus_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Cache models: ph 0 idle, 1 address, 2 write data, 3 read response.
  int          c_ph   [2];
  int          c_beat [2];
  logic        c_rd   [2];
  logic [63:0] c_cur  [2];
  logic [63:0] c_addr [2][$];

  // Bus model: ph 0 waiting for address, 1 write data, 2 read response.
  int          b_ph;
  int          b_beat;
  logic [63:0] b_addr;
  logic        ack_toggle;
  logic        spurious;

  // Scoreboard kinds: 0 bus address, 1 bus write beat, 2 icache resp, 3 dcache resp, 4 grant gap.
  logic [63:0] exp_q [5][$];
  logic [63:0] obs_q [5][$];
  int          last_done;
  logic        prev_reqcyc;
  logic        smp_bus_reqcyc, smp_bus_respack, smp_i_respcyc, smp_d_respcyc;

  function automatic logic [236:0] all_outs();
    return {bus_if.req, bus_if.reqtag, bus_if.reqcyc, bus_if.respack,
            icache_if.reqack, icache_if.resp, icache_if.resptag, icache_if.respcyc,
            dcache_if.reqack, dcache_if.resp, dcache_if.resptag, dcache_if.respcyc};
  endfunction

  // Read data the bus model returns for address a is (a & 0xFFF) + beat.
  task automatic push_read(input int c, input logic [63:0] a);
    exp_q[0].push_back(a);
    for (int k = 0; k < 8; k++) exp_q[2 + c].push_back((a & 64'hFFF) + 64'(k));
  endtask

  task automatic drive();
    logic [63:0] creq [2];
    logic        ccyc [2];
    logic        cack [2];
    for (int c = 0; c < 2; c++) begin
      ccyc[c] = (c_ph[c] == 1) || (c_ph[c] == 2);
      creq[c] = (c_ph[c] == 2) ? c_cur[c] + 64'(c_beat[c]) : c_cur[c];
      cack[c] = (c_ph[c] == 3);
    end
    icache_if.req     = creq[0];
    icache_if.reqtag  = {c_rd[0], 4'h0, 8'h00};
    icache_if.reqcyc  = ccyc[0];
    icache_if.respack = cack[0];
    dcache_if.req     = creq[1];
    dcache_if.reqtag  = {c_rd[1], 4'h0, 8'h00};
    dcache_if.reqcyc  = ccyc[1];
    dcache_if.respack = cack[1];
    bus_if.reqack     = ack_toggle ? ((cyc % 2) == 0) : 1'b1;
    bus_if.respcyc    = (b_ph == 2) || spurious;
    bus_if.resp       = (b_ph == 2) ? (b_addr & 64'hFFF) + 64'(b_beat) : 64'h0;
    bus_if.resptag    = 13'h1000;
  endtask

  task automatic sample();
    logic [1:0]  rc;
    logic [1:0]  ra;
    logic [63:0] rdat [2];
    cyc++;
    smp_bus_reqcyc  = bus_if.reqcyc;
    smp_bus_respack = bus_if.respack;
    smp_i_respcyc   = icache_if.respcyc;
    smp_d_respcyc   = dcache_if.respcyc;
    if (bus_if.reqcyc && !prev_reqcyc && (last_done >= 0)) obs_q[4].push_back(64'(cyc - last_done));
    prev_reqcyc = bus_if.reqcyc;
    case (b_ph)
      0: if (bus_if.reqcyc && bus_if.reqack) begin
           obs_q[0].push_back(bus_if.req);
           b_addr = bus_if.req;
           b_ph   = bus_if.reqtag[12] ? 2 : 1;
           b_beat = 0;
         end
      1: if (bus_if.reqcyc && bus_if.reqack) begin
           obs_q[1].push_back(bus_if.req);
           b_beat++;
           if (b_beat == 8) begin b_ph = 0; last_done = cyc; end
         end
      2: if (bus_if.respcyc && bus_if.respack) begin
           b_beat++;
           if (b_beat == 8) begin b_ph = 0; last_done = cyc; end
         end
      default: b_ph = 0;
    endcase
    rc = {dcache_if.respcyc, icache_if.respcyc};
    ra = {dcache_if.reqack, icache_if.reqack};
    rdat[0] = icache_if.resp;
    rdat[1] = dcache_if.resp;
    for (int c = 0; c < 2; c++) begin
      if (rc[c]) obs_q[2 + c].push_back(rdat[c]);
      case (c_ph[c])
        1: if (ra[c]) begin c_ph[c] = c_rd[c] ? 3 : 2; c_beat[c] = 0; end
        2: if (ra[c]) begin c_beat[c]++; if (c_beat[c] == 8) c_ph[c] = 0; end
        3: if (rc[c]) begin c_beat[c]++; if (c_beat[c] == 8) c_ph[c] = 0; end
        default: ;
      endcase
      if ((c_ph[c] == 0) && (c_addr[c].size() > 0)) begin
        c_cur[c] = c_addr[c].pop_front();
        c_ph[c]  = 1;
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int c = 0; c < 2; c++) begin
      c_ph[c] = 0; c_beat[c] = 0; c_rd[c] = 1'b1; c_cur[c] = 64'h0;
      c_addr[c].delete();
    end
    b_ph = 0; b_beat = 0; b_addr = 64'h0;
    ack_toggle = 1'b0; spurious = 1'b0;
    last_done = -1; prev_reqcyc = 1'b0;
    for (int k = 0; k < 5; k++) begin exp_q[k].delete(); obs_q[k].delete(); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_models();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_until_idle(input string name);
    int budget = 400;
    while (((c_ph[0] != 0) || (c_ph[1] != 0) || (b_ph != 0) ||
            (c_addr[0].size() > 0) || (c_addr[1].size() > 0)) && (budget > 0)) begin
      step();
      budget--;
    end
    tests_run++;
    if (budget == 0) begin
      tests_failed++;
      $display("FAIL %s timeout: got busy after 400 cycles, expected idle", name);
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_models();
    drive();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lone_read();
    logic [63:0] got, want;
    do_reset();
    c_rd[0] = 1'b1;
    c_addr[0].push_back(64'h1000);
    push_read(0, 64'h1000);
    step();
    step();
    tests_run++;
    if (smp_bus_reqcyc !== 1'b0) begin
      tests_failed++;
      $display("FAIL lone_latency_early: got bus.reqcyc=%b expected 0", smp_bus_reqcyc);
    end
    step();
    tests_run++;
    if (smp_bus_reqcyc !== 1'b1) begin
      tests_failed++;
      $display("FAIL lone_latency: got bus.reqcyc=%b expected 1", smp_bus_reqcyc);
    end
    run_until_idle("lone_read");
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (obs_q[k].size() !== exp_q[k].size()) begin
        tests_failed++;
        $display("FAIL lone_read count[%0d]: got %0d expected %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while ((obs_q[k].size() > 0) && (exp_q[k].size() > 0)) begin
        got = obs_q[k].pop_front(); want = exp_q[k].pop_front(); tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL lone_read data[%0d]: got %h expected %h", k, got, want);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [63:0] got, want;
    do_reset();
    c_rd[0] = 1'b1; c_rd[1] = 1'b1;
    c_addr[0].push_back(64'h1100); c_addr[0].push_back(64'h1300);
    c_addr[1].push_back(64'h2200); c_addr[1].push_back(64'h2400); c_addr[1].push_back(64'h2600);
`ifdef ARB_DCACHE_PRIORITY_EN
    push_read(1, 64'h2200); push_read(1, 64'h2400); push_read(1, 64'h2600);
    push_read(0, 64'h1100); push_read(0, 64'h1300);
`else
    push_read(0, 64'h1100); push_read(1, 64'h2200); push_read(0, 64'h1300);
    push_read(1, 64'h2400); push_read(1, 64'h2600);
`endif
    for (int k = 0; k < 4; k++) exp_q[4].push_back(64'd2);
    run_until_idle("contention");
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (obs_q[k].size() !== exp_q[k].size()) begin
        tests_failed++;
        $display("FAIL contention count[%0d]: got %0d expected %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while ((obs_q[k].size() > 0) && (exp_q[k].size() > 0)) begin
        got = obs_q[k].pop_front(); want = exp_q[k].pop_front(); tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL contention data[%0d]: got %h expected %h", k, got, want);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [63:0] got, want;
    do_reset();
    ack_toggle = 1'b1;
    c_rd[1] = 1'b0; c_rd[0] = 1'b1;
    c_addr[1].push_back(64'h2800);
    exp_q[0].push_back(64'h2800);
    for (int k = 0; k < 8; k++) exp_q[1].push_back(64'h2800 + 64'(k));
    repeat (4) step();
    c_addr[0].push_back(64'h1800);
    push_read(0, 64'h1800);
    exp_q[4].push_back(64'd2);
    run_until_idle("write");
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (obs_q[k].size() !== exp_q[k].size()) begin
        tests_failed++;
        $display("FAIL write count[%0d]: got %0d expected %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while ((obs_q[k].size() > 0) && (exp_q[k].size() > 0)) begin
        got = obs_q[k].pop_front(); want = exp_q[k].pop_front(); tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL write data[%0d]: got %h expected %h", k, got, want);
        end
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({smp_bus_respack, smp_i_respcyc, smp_d_respcyc} !== 3'b000) begin
        tests_failed++;
        $display("FAIL spurious_resp: got respack/i.respcyc/d.respcyc=%b%b%b expected 000",
                 smp_bus_respack, smp_i_respcyc, smp_d_respcyc);
      end
    end
    spurious = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, want;
    int budget = 100;
    do_reset();
    c_addr[0].push_back(64'h1A00);
    exp_q[0].push_back(64'h1A00);
    for (int k = 0; k < 3; k++) exp_q[2].push_back(64'hA00 + 64'(k));
    while ((obs_q[2].size() < 3) && (budget > 0)) begin step(); budget--; end
    tests_run++;
    if (budget == 0) begin
      tests_failed++;
      $display("FAIL reset_mid timeout: got %0d beats expected 3", obs_q[2].size());
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
    end
    for (int k = 0; k < 5; k++) begin
      while ((obs_q[k].size() > 0) && (exp_q[k].size() > 0)) begin
        got = obs_q[k].pop_front(); want = exp_q[k].pop_front(); tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL reset_mid partial[%0d]: got %h expected %h", k, got, want);
        end
      end
    end
    do_reset();
    c_addr[0].push_back(64'h1C00);
    push_read(0, 64'h1C00);
    run_until_idle("reset_mid_after");
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (obs_q[k].size() !== exp_q[k].size()) begin
        tests_failed++;
        $display("FAIL reset_mid_after count[%0d]: got %0d expected %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while ((obs_q[k].size() > 0) && (exp_q[k].size() > 0)) begin
        got = obs_q[k].pop_front(); want = exp_q[k].pop_front(); tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL reset_mid_after data[%0d]: got %h expected %h", k, got, want);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lone_read();
    test_contention();
    test_write();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
